// File: rtl/dsm_dec_pkg.sv
// Shared widths, droop-compensation coefficients and FSM states for the CIC decimation chain.
package dsm_dec_pkg;

   localparam int DATA_W = 24;
   localparam int COEF_W = 18;
   localparam int ACC_W  = 48;
   localparam int NTAPS  = 11;
   localparam int NHALF  = (NTAPS + 1) / 2;

   // First half of the symmetric response; c[10-k] = c[k]; taps sum to 65536 (unity DC gain).
   localparam logic signed [COEF_W-1:0] COMP_COEF [0:NHALF-1] = '{
      -18'sd196, 18'sd524, -18'sd1310, 18'sd3276, -18'sd9830, 18'sd80608
   };

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      ROUND
   } fir_state_e;

   localparam int                      RND_SHIFT = 16;
   localparam logic signed [ACC_W-1:0] RND_HALF  = ACC_W'(32768);
   localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((1 <<< (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-(1 <<< (DATA_W - 1)));

   // Q2.16 accumulator back to a sample: round half up, then clip to the output range.
   function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sum;
      logic signed [ACC_W-1:0] r;
      sum = acc + RND_HALF;
      r   = sum >>> RND_SHIFT;
      if (r > SAT_MAX) begin
         r = SAT_MAX;
      end else if (r < SAT_MIN) begin
         r = SAT_MIN;
      end
      return r[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Pre-add / multiply / accumulate datapath shared by all taps of the symmetric FIR.
module fir_mac_unit
   import dsm_dec_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clear,
   input  logic                     i_en,
   input  logic signed [DATA_W-1:0] i_tap_a,
   input  logic signed [DATA_W-1:0] i_tap_b,
   input  logic signed [COEF_W-1:0] i_coef,
   output logic signed [ACC_W-1:0]  o_acc
);

   localparam int PROD_W = DATA_W + COEF_W + 1;

   logic signed [DATA_W:0]   w_preadd;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  r_acc;

   // One extra bit so x[k] + x[10-k] can never wrap.
   assign w_preadd = (DATA_W + 1)'(i_tap_a) + (DATA_W + 1)'(i_tap_b);
   assign w_prod   = PROD_W'(w_preadd) * PROD_W'(i_coef);

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + ACC_W'(w_prod);
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/comp_fir_decimator.sv
// CIC droop-compensation FIR with decimate-by-2: delay line, MAC sequencer, round/saturate, flags.
module comp_fir_decimator
   import dsm_dec_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     overrun
);

   localparam int K_W   = $clog2(NHALF);
   localparam int IDX_W = $clog2(NTAPS);

   fir_state_e               r_state;
   fir_state_e               w_next_state;
   logic [K_W-1:0]           r_k;
   logic                     r_phase;
   logic signed [DATA_W-1:0] r_x [0:NTAPS-1];

   logic                     w_accept;
   logic                     w_start;
   logic                     w_mac_en;
   logic                     w_centre;
   logic [IDX_W-1:0]         w_idx_a;
   logic [IDX_W-1:0]         w_idx_b;
   logic signed [DATA_W-1:0] w_tap_a;
   logic signed [DATA_W-1:0] w_tap_b;
   logic signed [COEF_W-1:0] w_coef;
   logic signed [ACC_W-1:0]  w_acc;

   logic signed [DATA_W-1:0] r_round;
   logic                     r_round_vld;
   logic signed [DATA_W-1:0] r_out_data;
   logic                     r_out_valid;
   logic                     r_overrun;

   assign in_ready = (r_state == IDLE);
   assign w_accept = in_valid & in_ready;
   // Only the accept that flips phase 0 -> 1 produces an output sample.
   assign w_start  = w_accept & ~r_phase;
   assign w_mac_en = (r_state == MAC);
   assign w_centre = (r_k == K_W'(NHALF - 1));

   assign w_idx_a  = IDX_W'(r_k);
   assign w_idx_b  = IDX_W'(NTAPS - 1) - IDX_W'(r_k);
   assign w_tap_a  = r_x[w_idx_a];
   assign w_tap_b  = w_centre ? '0 : r_x[w_idx_b];
   assign w_coef   = COMP_COEF[r_k];

   // NOTE: the delay line is reset explicitly: it is only 11 words and must read as zeros
   // for the first outputs after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++) begin
            r_x[i] <= '0;
         end
         r_phase <= 1'b0;
      end else if (w_accept) begin
         r_x[0] <= in_data;
         for (int i = 1; i < NTAPS; i++) begin
            r_x[i] <= r_x[i-1];
         end
         r_phase <= ~r_phase;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_start) begin
            r_k <= '0;
         end else if (w_mac_en) begin
            r_k <= r_k + K_W'(1);
         end
      end
   end

   // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next_state = MAC;
         MAC:     if (w_centre) w_next_state = ROUND;
         ROUND:   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   fir_mac_unit u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_start),
      .i_en    (w_mac_en),
      .i_tap_a (w_tap_a),
      .i_tap_b (w_tap_b),
      .i_coef  (w_coef),
      .o_acc   (w_acc)
   );

   // Rounded result is staged one cycle, then published with the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_round     <= '0;
         r_round_vld <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_round_vld <= (r_state == ROUND);
         if (r_state == ROUND) begin
            r_round <= round_sat(w_acc);
         end
         r_out_valid <= r_round_vld;
         if (r_round_vld) begin
            r_out_data <= r_round;
         end
         if (in_valid & ~in_ready) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign overrun   = r_overrun;

endmodule
